norm_pipe: RTL and testbench
============================

Name: norm_pipe

Overview:
- Two-stage elastic normalization pipeline. Takes an unnormalized mantissa and exponent, counts leading zeros with the generic leading-zero counter (lzc), left-shifts the mantissa so its MSB is 1, and decrements the exponent by the shift amount.
- Sits downstream of FPU add/sub and conversion datapaths, upstream of rounding.
- Valid/ready handshake on both sides; sustains full throughput of one result per cycle.

Parameters:
- WIDTH, 8, mantissa width in bits; power of two, ≥ 2.
- EW, 8, unsigned input exponent width.
- CBITS, $clog2(WIDTH+1), leading-zero count width (derived; do not override).

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous, active-low reset
- Flush  in  1  synchronous pipeline flush
- InValid  in  1  input operand valid
- InReady  out  1  pipeline can accept an operand this cycle
- InMant  in  WIDTH  unnormalized mantissa
- InExp  in  EW  unsigned biased exponent
- InSign  in  1  sign, passed through
- OutValid  out  1  result valid
- OutReady  in  1  consumer accepts result
- OutMant  out  WIDTH  normalized mantissa
- OutExp  out  EW+1  signed (two's complement) adjusted exponent
- OutSign  out  1  sign
- OutZero  out  1  mantissa was all zeros
- OutUflow  out  1  adjusted exponent ≤ 0 and not OutZero

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-low, on resetn. While resetn=0 at a rising edge, all valid bits and all data registers clear to 0. OutValid, OutMant, OutExp, OutSign, OutZero and OutUflow all read 0 after reset. InReady reads 1 after reset.
- Stage 1 (S1):
  - On accept (InValid & InReady), register InMant, InExp and InSign.
  - Register Cnt = lzc(InMant), CBITS wide, computed combinationally from InMant before the register.
  - Set S1Valid.
- Stage 2 (S2):
  - On advance from S1, register Mant = S1Mant << S1Cnt, with zeros shifted in.
  - Exp = {1'b0,S1Exp} − {0,S1Cnt}, computed at EW+1 bits, two's complement.
  - Zero = (S1Cnt == WIDTH).
  - Uflow = ~Zero & (Exp ≤ 0, signed).
  - When Zero: force Exp = 0 and Mant = 0.
  - Sign passes through.
  - Outputs are driven directly from the S2 registers.
- Handshake:
  - S2Rdy = ~S2Valid | OutReady.
  - S1Rdy = ~S1Valid | S2Rdy.
  - InReady = S1Rdy & ~Flush.
  - S1 advances into S2 when S1Valid & S2Rdy.
  - S2Valid next = (S1Valid & S2Rdy) | (S2Valid & ~OutReady).
- Latency and throughput:
  - Exactly 2 cycles from accept to OutValid when there is no backpressure.
  - Back-to-back accepts with OutReady held at 1 give one result per cycle.
- Backpressure:
  - While OutValid & ~OutReady, S2 holds all output values stable.
  - S1 may still fill if empty. With both stages full, InReady = 0.
  - When OutReady rises, S2 takes S1's content in the same cycle and S1 may accept new input in that same cycle. No bubble, no loss, no duplication.
- Flush:
  - Flush=1 at an edge clears S1Valid and S2Valid.
  - Data registers may hold stale values.
  - InReady is 0 during Flush, so no operand is accepted in a flush cycle.
  - Flush has priority over advance and over acceptance.
  - resetn has priority over Flush.
- Reset mid-operation: in-flight operands are discarded and no OutValid follows.
- Boundaries:
  - InMant MSB set: Cnt = 0, OutMant = InMant, OutExp = InExp.
  - InMant = 1: Cnt = WIDTH−1.
  - InExp = 0 with nonzero mantissa: Uflow whenever Cnt ≥ 0.
  - InExp = 2^EW−1, Cnt = 0: OutExp = 2^EW−1, positive; no overflow possible.
- Implementation notes:
  - Instantiate lzc; no behavioural loops.
  - The shifter is a logarithmic barrel using the CBITS-bit count.

Test Plan:
- Single op, no stall (WIDTH=8, EW=8): InMant=0x0B, InExp=10, InSign=1 at cycle 0 -> cycle 2: OutValid=1, OutMant=0xB0, OutExp=6, OutSign=1, OutZero=0, OutUflow=0.
- Zero and underflow:
  - InMant=0x00, InExp=5 -> OutZero=1, OutMant=0, OutExp=0, OutUflow=0.
  - Then InMant=0x04, InExp=3 -> OutMant=0x80, OutExp=−2 (9'h1FE), OutUflow=1.
- Streaming: 8 consecutive operands with OutReady=1 -> 8 results on consecutive cycles starting 2 cycles after the first accept, in order, InReady constantly 1.
- Backpressure: stream 4 ops, OutReady=0 for 5 cycles after the first OutValid -> InReady falls once both stages are full, OutMant/OutExp stay stable. After OutReady=1, the remaining results appear in order with no loss or duplication.
- Flush: accept op A, flush the next cycle while InValid=1 for op B -> no OutValid for A or B, InReady=0 during the flush cycle, the following op C emerges 2 cycles after its accept.
- Reset: resetn=0 for 1 cycle with both stages full -> next cycle OutValid=0, all outputs 0, InReady=1, and no stale result is produced afterwards.

Source files
------------

// File: rtl/norm_pipe_if.sv
// Handshake and data bundle for the normalization pipeline.
// master: the operand producer / result consumer side; slave: the pipeline.
interface norm_pipe_if #(
   parameter int WIDTH = 8,
   parameter int EW    = 8
);
   logic                 InValid;
   logic                 InReady;
   logic [WIDTH-1:0]     InMant;
   logic [EW-1:0]        InExp;
   logic                 InSign;
   logic                 OutValid;
   logic                 OutReady;
   logic [WIDTH-1:0]     OutMant;
   logic signed [EW:0]   OutExp;
   logic                 OutSign;
   logic                 OutZero;
   logic                 OutUflow;

   modport master (
      output InValid, InMant, InExp, InSign, OutReady,
      input  InReady, OutValid, OutMant, OutExp, OutSign, OutZero, OutUflow
   );

   modport slave (
      input  InValid, InMant, InExp, InSign, OutReady,
      output InReady, OutValid, OutMant, OutExp, OutSign, OutZero, OutUflow
   );
endinterface

// File: rtl/norm_pipe.sv
// Two-stage elastic normalization pipeline: leading-zero count in stage 1,
// barrel left-shift and exponent adjustment in stage 2. Also holds the
// generic recursive leading-zero counter used by stage 1.

// Leading-zero counter for power-of-two widths. Built as a binary tree of
// half-width counters; an all-zero input yields WIDTH (MSB of the count set).
module lzc #(
   parameter  int WIDTH = 8,
   localparam int CBITS = $clog2(WIDTH + 1)
) (
   input  logic [WIDTH-1:0] in_i,
   output logic [CBITS-1:0] cnt_o
);
   generate
      if (WIDTH == 2) begin : g_leaf
         assign cnt_o = {~in_i[1] & ~in_i[0], ~in_i[1] & in_i[0]};
      end else begin : g_node
         localparam int HW = WIDTH / 2;
         localparam int HB = $clog2(HW + 1);
         logic [HB-1:0] hi_cnt;
         logic [HB-1:0] lo_cnt;

         lzc #(.WIDTH(HW)) u_hi (.in_i(in_i[WIDTH-1:HW]), .cnt_o(hi_cnt));
         lzc #(.WIDTH(HW)) u_lo (.in_i(in_i[HW-1:0]),     .cnt_o(lo_cnt));

         // An all-zero upper half adds HW to the lower count; HW + lo_cnt is
         // formed by bit placement since lo_cnt never exceeds HW.
         assign cnt_o = hi_cnt[HB-1] ? {lo_cnt[HB-1], ~lo_cnt[HB-1], lo_cnt[HB-2:0]}
                                     : {1'b0, hi_cnt};
      end
   endgenerate
endmodule

module norm_pipe #(
   parameter  int WIDTH = 8,
   parameter  int EW    = 8,
   localparam int CBITS = $clog2(WIDTH + 1)
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        Flush,
   norm_pipe_if.slave  bus
);
   // Exponent minus shift amount, two's complement at EW+1 bits.
   function automatic logic signed [EW:0] adj_exp(input logic [EW-1:0] e,
                                                  input logic [CBITS-1:0] c);
      logic [EW:0] diff;
      diff    = {1'b0, e} - (EW+1)'(c);
      adj_exp = $signed(diff);
   endfunction

   logic                 rdy_p1, rdy_p2, accept, adv;

   logic [CBITS-1:0]     cnt_p0;

   logic                 vld_p1_q, vld_p1_d;
   logic [WIDTH-1:0]     mant_p1_q, mant_p1_d;
   logic [EW-1:0]        exp_p1_q, exp_p1_d;
   logic                 sign_p1_q, sign_p1_d;
   logic [CBITS-1:0]     cnt_p1_q, cnt_p1_d;

   logic [WIDTH-1:0]     shl_p1 [0:CBITS-1];
   logic signed [EW:0]   exp_adj_p1;
   logic                 zero_p1;

   logic                 vld_p2_q, vld_p2_d;
   logic [WIDTH-1:0]     mant_p2_q, mant_p2_d;
   logic signed [EW:0]   exp_p2_q, exp_p2_d;
   logic                 sign_p2_q, sign_p2_d;
   logic                 zero_p2_q, zero_p2_d;
   logic                 uflow_p2_q, uflow_p2_d;

   // ---- handshake: each stage is free when empty or when it drains this cycle
   assign rdy_p2      = ~vld_p2_q | bus.OutReady;
   assign rdy_p1      = ~vld_p1_q | rdy_p2;
   assign bus.InReady = rdy_p1 & ~Flush;
   assign accept      = bus.InValid & bus.InReady;
   assign adv         = vld_p1_q & rdy_p2;

   // ---- stage 0 -> 1: leading-zero count of the incoming mantissa
   lzc #(.WIDTH(WIDTH)) u_lzc (.in_i(bus.InMant), .cnt_o(cnt_p0));

   // Stage 1 next state: load on accept, empty on advance, flush wins.
   always_comb begin
      vld_p1_d  = vld_p1_q;
      mant_p1_d = mant_p1_q;
      exp_p1_d  = exp_p1_q;
      sign_p1_d = sign_p1_q;
      cnt_p1_d  = cnt_p1_q;
      if (Flush) begin
         vld_p1_d = 1'b0;
      end else if (accept) begin
         vld_p1_d  = 1'b1;
         mant_p1_d = bus.InMant;
         exp_p1_d  = bus.InExp;
         sign_p1_d = bus.InSign;
         cnt_p1_d  = cnt_p0;
      end else if (adv) begin
         vld_p1_d = 1'b0;
      end
   end

   // ---- stage 1 -> 2: logarithmic barrel shift by the count, one level per
   // count bit; the top bit (shift by WIDTH) only occurs for a zero mantissa,
   // which is forced to zero below.
   assign shl_p1[0] = mant_p1_q;
   generate
      for (genvar k = 0; k < CBITS - 1; k++) begin : g_shl
         assign shl_p1[k+1] = cnt_p1_q[k] ? (shl_p1[k] << (2**k)) : shl_p1[k];
      end
   endgenerate

   assign zero_p1    = (cnt_p1_q == CBITS'(WIDTH));
   assign exp_adj_p1 = adj_exp(exp_p1_q, cnt_p1_q);

   // Stage 2 next state: take stage 1 on advance, hold while stalled.
   always_comb begin
      mant_p2_d  = mant_p2_q;
      exp_p2_d   = exp_p2_q;
      sign_p2_d  = sign_p2_q;
      zero_p2_d  = zero_p2_q;
      uflow_p2_d = uflow_p2_q;
      vld_p2_d   = Flush ? 1'b0 : (adv | (vld_p2_q & ~bus.OutReady));
      if (adv) begin
         mant_p2_d  = zero_p1 ? '0 : shl_p1[CBITS-1];
         exp_p2_d   = zero_p1 ? '0 : exp_adj_p1;
         sign_p2_d  = sign_p1_q;
         zero_p2_d  = zero_p1;
         uflow_p2_d = ~zero_p1 & (exp_adj_p1 <= 0);
      end
   end

   // Pipeline registers; reset clears valid bits and data alike.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         vld_p1_q   <= 1'b0;
         mant_p1_q  <= '0;
         exp_p1_q   <= '0;
         sign_p1_q  <= 1'b0;
         cnt_p1_q   <= '0;
         vld_p2_q   <= 1'b0;
         mant_p2_q  <= '0;
         exp_p2_q   <= '0;
         sign_p2_q  <= 1'b0;
         zero_p2_q  <= 1'b0;
         uflow_p2_q <= 1'b0;
      end else begin
         vld_p1_q   <= vld_p1_d;
         mant_p1_q  <= mant_p1_d;
         exp_p1_q   <= exp_p1_d;
         sign_p1_q  <= sign_p1_d;
         cnt_p1_q   <= cnt_p1_d;
         vld_p2_q   <= vld_p2_d;
         mant_p2_q  <= mant_p2_d;
         exp_p2_q   <= exp_p2_d;
         sign_p2_q  <= sign_p2_d;
         zero_p2_q  <= zero_p2_d;
         uflow_p2_q <= uflow_p2_d;
      end
   end

   // ---- stage 2 outputs straight from registers
   assign bus.OutValid = vld_p2_q;
   assign bus.OutMant  = mant_p2_q;
   assign bus.OutExp   = exp_p2_q;
   assign bus.OutSign  = sign_p2_q;
   assign bus.OutZero  = zero_p2_q;
   assign bus.OutUflow = uflow_p2_q;
endmodule

// File: tb/tb_norm_pipe.sv
// Directed bench for norm_pipe with an in-order scoreboard of expected results.
module tb_norm_pipe;
   localparam int WIDTH = 8;
   localparam int EW    = 8;

   typedef struct {
      logic [WIDTH-1:0]   mant;
      logic signed [EW:0] exp;
      logic               sign;
      logic               zero;
      logic               uflow;
      int                 acc;
      bit                 seen;
   } exp_t;

   logic clk    = 1'b0;
   logic resetn = 1'b0;
   logic Flush  = 1'b0;

   norm_pipe_if #(.WIDTH(WIDTH), .EW(EW)) bus ();
   norm_pipe #(.WIDTH(WIDTH), .EW(EW)) dut (
      .clk(clk), .resetn(resetn), .Flush(Flush), .bus(bus)
   );

   always #5 clk = ~clk;

   exp_t sb[$];
   int   checks  = 0;
   int   errors  = 0;
   int   cyc     = 0;
   int   nout    = 0;
   bit   lat_chk = 0;
   bit   mon_en  = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Independent reference: count from the top set bit, shift, adjust.
   function automatic exp_t model(input logic [WIDTH-1:0] m, input logic [EW-1:0] e, input logic s);
      exp_t r;
      int   c;
      int   ex;
      c = WIDTH;
      for (int i = 0; i < WIDTH; i++) if (m[i]) c = WIDTH - 1 - i;
      ex      = int'(e) - c;
      r.zero  = (m == '0);
      r.sign  = s;
      r.mant  = r.zero ? '0 : (m << c);
      r.exp   = r.zero ? '0 : (EW+1)'(ex);
      r.uflow = !r.zero && (ex <= 0);
      r.acc   = 0;
      r.seen  = 0;
      return r;
   endfunction

   // Output side: compare the head entry every cycle it is shown, pop on transfer.
   // Input side: push the model result when an accept is about to happen.
   always @(negedge clk) begin
      exp_t e;
      exp_t n;
      if (mon_en) begin
         if (bus.OutValid) begin
            checks++;
            assert (sb.size() != 0) else begin
               errors++;
               $error("FAIL spurious_out observed=OutValid=1 expected=no result pending");
            end
            if (sb.size() != 0) begin
               e = sb[0];
               chk("out_mant",  32'(bus.OutMant), 32'(e.mant));
               chk("out_exp",   {23'b0, bus.OutExp}, {23'b0, e.exp});
               chk("out_sign",  32'(bus.OutSign), 32'(e.sign));
               chk("out_zero",  32'(bus.OutZero), 32'(e.zero));
               chk("out_uflow", 32'(bus.OutUflow), 32'(e.uflow));
               if (lat_chk && !e.seen) chk("latency", 32'(cyc - e.acc), 32'd2);
               sb[0].seen = 1;
               if (bus.OutReady) begin
                  void'(sb.pop_front());
                  nout++;
               end
            end
         end
         if (!resetn || Flush) begin
            sb.delete();
         end else if (bus.InValid && bus.InReady) begin
            n = model(bus.InMant, bus.InExp, bus.InSign);
            n.acc = cyc;
            sb.push_back(n);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present an operand and hold it until accepted (bounded); returns at accept edge + 1.
   task automatic send(input logic [WIDTH-1:0] m, input logic [EW-1:0] e, input logic s,
                       output bit rdy0);
      bit acc;
      int n;
      n = 0;
      bus.InValid = 1'b1;
      bus.InMant  = m;
      bus.InExp   = e;
      bus.InSign  = s;
      @(negedge clk);
      acc  = bus.InReady;
      rdy0 = acc;
      while (!acc && n < 50) begin
         step();
         @(negedge clk);
         acc = bus.InReady;
         n++;
      end
      if (!acc) chk("send_timeout", 32'(acc), 32'd1);
      step();
   endtask

   initial begin
      bit               r;
      int               base;
      logic [WIDTH-1:0] held_mant;
      logic [EW:0]      held_exp;
      logic [WIDTH-1:0] smant [8];
      logic [EW-1:0]    sexp  [8];

      smant = '{8'h80, 8'h01, 8'h80, 8'h3C, 8'hFF, 8'h02, 8'h40, 8'h00};
      sexp  = '{8'd255, 8'd20, 8'd0, 8'd7, 8'd1, 8'd1, 8'd2, 8'd9};

      bus.InValid  = 1'b0;
      bus.InMant   = '0;
      bus.InExp    = '0;
      bus.InSign   = 1'b0;
      bus.OutReady = 1'b1;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_outvalid", 32'(bus.OutValid), 32'd0);
      chk("rst_outmant",  32'(bus.OutMant),  32'd0);
      chk("rst_outexp",   {23'b0, bus.OutExp}, 32'd0);
      chk("rst_outsign",  32'(bus.OutSign),  32'd0);
      chk("rst_outzero",  32'(bus.OutZero),  32'd0);
      chk("rst_outuflow", 32'(bus.OutUflow), 32'd0);
      chk("rst_inready",  32'(bus.InReady),  32'd1);
      step();
      resetn = 1'b1;
      mon_en = 1'b1;
      step();

      // Single op, no stall
      lat_chk = 1;
      base = nout;
      send(8'h0B, 8'd10, 1'b1, r);
      bus.InValid = 1'b0;
      @(negedge clk);
      chk("single_s1_only", 32'(bus.OutValid), 32'd0);
      @(negedge clk);
      chk("single_valid", 32'(bus.OutValid), 32'd1);
      chk("single_mant",  32'(bus.OutMant), 32'h0B0);
      chk("single_exp",   {23'b0, bus.OutExp}, 32'd6);
      chk("single_sign",  32'(bus.OutSign), 32'd1);
      repeat (3) step();
      chk("single_count", 32'(nout - base), 32'd1);

      // Zero mantissa then underflow
      base = nout;
      send(8'h00, 8'd5, 1'b0, r);
      send(8'h04, 8'd3, 1'b0, r);
      bus.InValid = 1'b0;
      @(negedge clk);
      chk("zero_flag",  32'(bus.OutZero),  32'd1);
      chk("zero_mant",  32'(bus.OutMant),  32'd0);
      chk("zero_exp",   {23'b0, bus.OutExp}, 32'd0);
      chk("zero_uflow", 32'(bus.OutUflow), 32'd0);
      @(negedge clk);
      chk("uf_mant",  32'(bus.OutMant),  32'h080);
      chk("uf_exp",   {23'b0, bus.OutExp}, 32'h1FE);
      chk("uf_uflow", 32'(bus.OutUflow), 32'd1);
      repeat (3) step();
      chk("zero_uf_count", 32'(nout - base), 32'd2);

      // Streaming, full throughput
      base = nout;
      for (int i = 0; i < 8; i++) begin
         send(smant[i], sexp[i], 1'(i), r);
         chk("stream_inready", 32'(r), 32'd1);
      end
      bus.InValid = 1'b0;
      repeat (4) step();
      chk("stream_count", 32'(nout - base), 32'd8);
      chk("stream_sb_empty", 32'(sb.size()), 32'd0);

      // Backpressure
      lat_chk = 0;
      base = nout;
      bus.OutReady = 1'b0;
      send(8'h21, 8'd40, 1'b0, r);
      send(8'h07, 8'd3, 1'b1, r);
      bus.InMant  = 8'hC0;
      bus.InExp   = 8'd100;
      bus.InSign  = 1'b0;
      bus.InValid = 1'b1;
      @(negedge clk);
      held_mant = bus.OutMant;
      held_exp  = bus.OutExp;
      for (int i = 0; i < 5; i++) begin
         if (i != 0) @(negedge clk);
         chk("bp_inready",  32'(bus.InReady),  32'd0);
         chk("bp_outvalid", 32'(bus.OutValid), 32'd1);
         chk("bp_mant_hold", 32'(bus.OutMant), 32'(held_mant));
         chk("bp_exp_hold",  {23'b0, bus.OutExp}, {23'b0, held_exp});
         step();
      end
      bus.OutReady = 1'b1;
      send(8'hC0, 8'd100, 1'b0, r);
      chk("bp_release_ready", 32'(r), 32'd1);
      send(8'h01, 8'd2, 1'b1, r);
      bus.InValid = 1'b0;
      repeat (5) step();
      chk("bp_count", 32'(nout - base), 32'd4);
      chk("bp_sb_empty", 32'(sb.size()), 32'd0);

      // Flush
      lat_chk = 1;
      base = nout;
      send(8'h33, 8'd50, 1'b0, r);
      bus.InMant  = 8'h44;
      bus.InExp   = 8'd60;
      bus.InValid = 1'b1;
      Flush       = 1'b1;
      @(negedge clk);
      chk("flush_inready", 32'(bus.InReady), 32'd0);
      step();
      Flush       = 1'b0;
      bus.InValid = 1'b0;
      step();
      send(8'h10, 8'd30, 1'b1, r);
      bus.InValid = 1'b0;
      repeat (5) step();
      chk("flush_count", 32'(nout - base), 32'd1);

      // Reset with both stages full
      lat_chk = 0;
      base = nout;
      bus.OutReady = 1'b0;
      send(8'h55, 8'd70, 1'b1, r);
      send(8'h0F, 8'd80, 1'b1, r);
      bus.InValid = 1'b0;
      resetn = 1'b0;
      step();
      resetn = 1'b1;
      bus.OutReady = 1'b1;
      @(negedge clk);
      chk("mrst_outvalid", 32'(bus.OutValid), 32'd0);
      chk("mrst_outmant",  32'(bus.OutMant),  32'd0);
      chk("mrst_outexp",   {23'b0, bus.OutExp}, 32'd0);
      chk("mrst_outsign",  32'(bus.OutSign),  32'd0);
      chk("mrst_outzero",  32'(bus.OutZero),  32'd0);
      chk("mrst_outuflow", 32'(bus.OutUflow), 32'd0);
      chk("mrst_inready",  32'(bus.InReady),  32'd1);
      repeat (5) step();
      chk("mrst_count", 32'(nout - base), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=completion");
      $fatal(1, "bench timeout");
   end
endmodule
